// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access stage.
//   mem_size_e : encoding of the memSize request field
//   exc_code_e : encoding of the excCode response field
//   state_e    : access sequencer states
//   is_misaligned() : natural-alignment test for a request size and byte offset
package mem_access_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        EXC_OK     = 2'b00,
        EXC_ADEL   = 2'b01,
        EXC_ADES   = 2'b10,
        EXC_BADCMD = 2'b11
    } exc_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MERGE,
        ST_WRITE,
        ST_DATA,
        ST_ERR
    } state_e;

    // Halves must sit on even bytes, words on byte 0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_low);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_HALF: mis = addr_low[0];
            SIZE_WORD: mis = (addr_low != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling for the memory access stage.
//   word_in    : RAM word (read data)
//   addr_low   : byte offset within the word
//   mem_size   : access size (word/half/byte)
//   sign_ext   : 1 = sign-extend sub-word loads, 0 = zero-extend
//   store_data : store data, sub-word values right-justified
//   load_data  : addressed lane of word_in, extended to full width
//   merge_data : word_in with the addressed lane(s) replaced by store_data
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word_in,
    input  logic [1:0]        addr_low,
    input  logic [1:0]        mem_size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merge_data
);

    logic [4:0]          byte_off;
    logic [4:0]          half_off;
    logic [LANE_W-1:0]   byte_lane;
    logic [2*LANE_W-1:0] half_lane;

    always_comb begin
        // Little-endian: byte n occupies bits [8n+7:8n]; half lane picked by addr_low[1].
        byte_off   = {addr_low, 3'b000};
        half_off   = {addr_low[1], 4'b0000};
        byte_lane  = word_in[byte_off +: LANE_W];
        half_lane  = word_in[half_off +: 2*LANE_W];
        load_data  = word_in;
        merge_data = store_data;
        case (mem_size)
            SIZE_BYTE: begin
                load_data  = {{(DATA_W-LANE_W){sign_ext & byte_lane[LANE_W-1]}}, byte_lane};
                merge_data = word_in;
                merge_data[byte_off +: LANE_W] = store_data[LANE_W-1:0];
            end
            SIZE_HALF: begin
                load_data  = {{(DATA_W-2*LANE_W){sign_ext & half_lane[2*LANE_W-1]}}, half_lane};
                merge_data = word_in;
                merge_data[half_off +: 2*LANE_W] = store_data[2*LANE_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: sequences load/store requests onto a synchronous-read,
// word-write RAM. Sub-word stores are read-modify-write; loads are lane-extracted and
// extended. Address and command errors are reported without touching the RAM.
//   clk, rst                  : clock, synchronous active-high reset
//   reqValid/reqReady         : request handshake (one request in flight at a time)
//   memRead, memWrite         : load / store command
//   memSize, bitXtend         : access size, sign-extend select for sub-word loads
//   addrLow, physicalAddr     : byte offset, RAM word address
//   invAddr                   : decoder flagged an unmapped address
//   wdata                     : store data (sub-word right-justified)
//   rdata, respValid, excCode : response; rdata/excCode hold until the next response
//   ramAddr, ramWe, ramWdata  : RAM drive
//   ramRdata                  : RAM read data, one cycle after ramAddr
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [1:0]        memSize,
    input  logic              bitXtend,
    input  logic [1:0]        addrLow,
    input  logic [ADDR_W-1:0] physicalAddr,
    input  logic              invAddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              respValid,
    output logic [1:0]        excCode,
    output logic [ADDR_W-1:0] ramAddr,
    output logic              ramWe,
    output logic [DATA_W-1:0] ramWdata,
    input  logic [DATA_W-1:0] ramRdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        addr_low_q, addr_low_d;
    logic              xtend_q, xtend_d;
    logic              is_load_q, is_load_d;
    logic [1:0]        exc_pend_q, exc_pend_d;
    logic [1:0]        exc_hold_q, exc_hold_d;
    logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;

    logic              accept;
    logic              bad_cmd;
    logic              addr_err;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;
    logic [DATA_W-1:0] rdata_now;
    logic [1:0]        exc_now;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .word_in    (ramRdata),
        .addr_low   (addr_low_q),
        .mem_size   (size_q),
        .sign_ext   (xtend_q),
        .store_data (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        accept   = reqValid & (state_q == ST_IDLE) & (memRead | memWrite);
        bad_cmd  = (memRead & memWrite) | (memSize == SIZE_RSVD);
        addr_err = invAddr | is_misaligned(memSize, addrLow);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; full-word stores skip the read, sub-word stores read first to merge
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_cmd | addr_err) begin
                        state_d = ST_ERR;
                    end else if (memWrite && (memSize == SIZE_WORD)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: state_d = is_load_q ? ST_DATA : ST_MERGE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; rdata/excCode show the live response while respValid, else the held one
    always_comb begin
        reqReady  = (state_q == ST_IDLE);
        respValid = (state_q == ST_DATA) | (state_q == ST_WRITE) |
                    (state_q == ST_MERGE) | (state_q == ST_ERR);
        ramWe     = (state_q == ST_WRITE) | (state_q == ST_MERGE);
        ramAddr   = addr_q;
        ramWdata  = '0;
        if (state_q == ST_WRITE) begin
            ramWdata = wdata_q;
        end else if (state_q == ST_MERGE) begin
            ramWdata = merge_data;
        end
        rdata_now = (state_q == ST_DATA) ? load_data : '0;
        exc_now   = (state_q == ST_ERR) ? exc_pend_q : EXC_OK;
        rdata     = respValid ? rdata_now : rdata_hold_q;
        excCode   = respValid ? exc_now : exc_hold_q;
    end

    // Request latch and response hold registers
    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        addr_low_d   = addr_low_q;
        xtend_d      = xtend_q;
        is_load_d    = is_load_q;
        exc_pend_d   = exc_pend_q;
        if (accept) begin
            addr_d     = physicalAddr;
            wdata_d    = wdata;
            size_d     = memSize;
            addr_low_d = addrLow;
            xtend_d    = bitXtend;
            is_load_d  = memRead;
            if (bad_cmd) begin
                exc_pend_d = EXC_BADCMD;
            end else if (addr_err) begin
                exc_pend_d = memRead ? EXC_ADEL : EXC_ADES;
            end else begin
                exc_pend_d = EXC_OK;
            end
        end
        rdata_hold_d = respValid ? rdata_now : rdata_hold_q;
        exc_hold_d   = respValid ? exc_now : exc_hold_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            addr_low_q   <= '0;
            xtend_q      <= 1'b0;
            is_load_q    <= 1'b0;
            exc_pend_q   <= '0;
            exc_hold_q   <= '0;
            rdata_hold_q <= '0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            addr_low_q   <= addr_low_d;
            xtend_q      <= xtend_d;
            is_load_q    <= is_load_d;
            exc_pend_q   <= exc_pend_d;
            exc_hold_q   <= exc_hold_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed literal cases followed by randomized traffic,
// compared every cycle against a request-level behavioural model with its own memory image.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  memSize;
    logic        bitXtend;
    logic [1:0]  addrLow;
    logic [10:0] physicalAddr;
    logic        invAddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        respValid;
    logic [1:0]  excCode;
    logic [10:0] ramAddr;
    logic        ramWe;
    logic [31:0] ramWdata;
    logic [31:0] ramRdata;

    int errors = 0;
    int checks = 0;

    mem_access_unit #(.ADDR_W(11), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memSize      (memSize),
        .bitXtend     (bitXtend),
        .addrLow      (addrLow),
        .physicalAddr (physicalAddr),
        .invAddr      (invAddr),
        .wdata        (wdata),
        .rdata        (rdata),
        .respValid    (respValid),
        .excCode      (excCode),
        .ramAddr      (ramAddr),
        .ramWe        (ramWe),
        .ramWdata     (ramWdata),
        .ramRdata     (ramRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM attached to the DUT: synchronous read (old data on same-address write)
    logic [31:0] ram [0:2047];
    always @(posedge clk) begin
        ramRdata <= ram[ramAddr];
        if (ramWe === 1'b1) ram[ramAddr] = ramWdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] ref_mem [0:2047];

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] al, input logic xt);
        logic [31:0] v;
        if (sz == 2'd2) begin
            v = (w >> (8 * al)) & 32'h0000_00FF;
            if (xt && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * al[1])) & 32'h0000_FFFF;
            if (xt && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                                input logic [1:0] al, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        if (sz == 2'd2) begin
            sh   = 8 * al;
            mask = 32'h0000_00FF << sh;
        end else if (sz == 2'd1) begin
            sh   = 16 * al[1];
            mask = 32'h0000_FFFF << sh;
        end else begin
            sh   = 0;
            mask = 32'hFFFF_FFFF;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    logic        mon_on = 1'b0;
    int          ncyc = 0;
    logic        pend = 1'b0;
    int          pdue;
    logic [1:0]  pexc;
    logic        pload;
    logic [1:0]  psz;
    logic [1:0]  pal;
    logic        pxt;
    logic [10:0] paddr;
    logic [31:0] pwd;
    logic [1:0]  last_exc = 2'b00;
    logic [31:0] last_rdata = 32'h0;
    logic        rd_known = 1'b1;
    logic        busy;
    logic        exp_resp;
    logic [31:0] exp_val;
    logic        m_bad;
    logic        m_adr;
    int          m_lat;

    always @(negedge clk) begin
        if (mon_on) begin
            busy     = pend;
            exp_resp = pend && (pdue == ncyc);
            chk("reqReady", {31'b0, reqReady}, {31'b0, !busy});
            chk("respValid", {31'b0, respValid}, {31'b0, exp_resp});
            if (exp_resp) begin
                chk("resp_excCode", {30'b0, excCode}, {30'b0, pexc});
                if (pexc != 2'b00) begin
                    chk("err_rdata", rdata, 32'h0);
                    chk("err_ramWe", {31'b0, ramWe}, 32'h0);
                    last_rdata = 32'h0;
                    rd_known   = 1'b1;
                end else if (pload) begin
                    exp_val = model_load(ref_mem[paddr], psz, pal, pxt);
                    chk("load_rdata", rdata, exp_val);
                    chk("load_ramWe", {31'b0, ramWe}, 32'h0);
                    last_rdata = exp_val;
                    rd_known   = 1'b1;
                end else begin
                    exp_val = model_store(ref_mem[paddr], psz, pal, pwd);
                    chk("store_ramWe", {31'b0, ramWe}, 32'h1);
                    chk("store_ramAddr", {21'b0, ramAddr}, {21'b0, paddr});
                    chk("store_ramWdata", ramWdata, exp_val);
                    ref_mem[paddr] = exp_val;
                    rd_known = 1'b0;
                end
                last_exc = pexc;
                pend     = 1'b0;
            end else begin
                chk("idle_ramWe", {31'b0, ramWe}, 32'h0);
                chk("hold_excCode", {30'b0, excCode}, {30'b0, last_exc});
                if (rd_known) chk("hold_rdata", rdata, last_rdata);
            end
            if (rst) begin
                pend       = 1'b0;
                last_exc   = 2'b00;
                last_rdata = 32'h0;
                rd_known   = 1'b1;
            end else if (reqValid && !busy && (memRead || memWrite)) begin
                m_bad = (memRead && memWrite) || (memSize == 2'd3);
                m_adr = invAddr || (memSize == 2'd1 && addrLow[0]) ||
                        (memSize == 2'd0 && addrLow != 2'd0);
                if (m_bad) pexc = 2'b11;
                else if (m_adr) pexc = memRead ? 2'b01 : 2'b10;
                else pexc = 2'b00;
                if (pexc != 2'b00) m_lat = 1;
                else if (memRead) m_lat = 2;
                else m_lat = (memSize == 2'd0) ? 1 : 2;
                pend  = 1'b1;
                pdue  = ncyc + m_lat;
                pload = memRead;
                psz   = memSize;
                pal   = addrLow;
                pxt   = bitXtend;
                paddr = physicalAddr;
                pwd   = wdata;
            end
        end
        ncyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; holds the request until it is taken, then drops reqValid.
    task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic xt,
                       input logic [1:0] al, input logic [10:0] pa, input logic inv,
                       input logic [31:0] wd);
        int   n;
        logic ok;
        reqValid = 1'b1; memRead = rd; memWrite = wr; memSize = sz; bitXtend = xt;
        addrLow = al; physicalAddr = pa; invAddr = inv; wdata = wd;
        n = 0; ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (reqReady === 1'b1) ok = 1'b1;
            n++;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("req_accept_timeout", 32'h0, 32'h1);
        reqValid = 1'b0;
    endtask

    // Called just after the accept edge; returns cycles until respValid and the response.
    task automatic wait_resp(output int lat, output logic [31:0] rd, output logic [1:0] ec,
                             output logic we, output logic [31:0] wdv);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (respValid !== 1'b1 && lat < 20);
        if (respValid !== 1'b1) chk("resp_timeout", 32'h0, 32'h1);
        rd = rdata; ec = excCode; we = ramWe; wdv = ramWdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int          lat;
    logic [31:0] r_rd;
    logic [1:0]  r_ec;
    logic        r_we;
    logic [31:0] r_wd;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            ram[i] = $urandom;
        end
        ram[5] = 32'h8899_AABB;
        ram[7] = 32'h0BAD_BEEF;
        for (int i = 0; i < 2048; i++) ref_mem[i] = ram[i];

        rst = 1'b1; reqValid = 1'b0; memRead = 1'b0; memWrite = 1'b0; memSize = 2'd0;
        bitXtend = 1'b0; addrLow = 2'd0; physicalAddr = 11'd0; invAddr = 1'b0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_reqReady", {31'b0, reqReady}, 32'h1);
        chk("rst_respValid", {31'b0, respValid}, 32'h0);
        chk("rst_ramWe", {31'b0, ramWe}, 32'h0);
        chk("rst_excCode", {30'b0, excCode}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ramAddr", {21'b0, ramAddr}, 32'h0);
        chk("rst_ramWdata", ramWdata, 32'h0);
        step();

        // lb, sign-extended top byte
        req(1, 0, 2'd2, 1, 2'd3, 11'd5, 0, 32'h0);
        wait_resp(lat, r_rd, r_ec, r_we, r_wd);
        chk("lb_latency", lat, 2);
        chk("lb_rdata", r_rd, 32'hFFFF_FF88);
        chk("lb_exc", {30'b0, r_ec}, 32'h0);
        step();
        req(1, 0, 2'd1, 0, 2'd2, 11'd5, 0, 32'h0);
        wait_resp(lat, r_rd, r_ec, r_we, r_wd);
        chk("lhu_rdata", r_rd, 32'h0000_8899);
        step();
        req(1, 0, 2'd1, 1, 2'd0, 11'd5, 0, 32'h0);
        wait_resp(lat, r_rd, r_ec, r_we, r_wd);
        chk("lh_rdata", r_rd, 32'hFFFF_AABB);
        step();

        // sb read-modify-write
        req(0, 1, 2'd2, 0, 2'd1, 11'd5, 0, 32'h1234_56CC);
        wait_resp(lat, r_rd, r_ec, r_we, r_wd);
        chk("sb_latency", lat, 2);
        chk("sb_ramWe", {31'b0, r_we}, 32'h1);
        chk("sb_ramWdata", r_wd, 32'h8899_CCBB);
        step();
        chk("sb_ram5", ram[5], 32'h8899_CCBB);

        // error cases
        req(0, 1, 2'd0, 0, 2'd2, 11'd5, 0, 32'hDEAD_0000);
        wait_resp(lat, r_rd, r_ec, r_we, r_wd);
        chk("sw_mis_exc", {30'b0, r_ec}, 32'h2);
        chk("sw_mis_ramWe", {31'b0, r_we}, 32'h0);
        chk("sw_mis_latency", lat, 1);
        step();
        req(1, 0, 2'd1, 1, 2'd1, 11'd5, 0, 32'h0);
        wait_resp(lat, r_rd, r_ec, r_we, r_wd);
        chk("lh_mis_exc", {30'b0, r_ec}, 32'h1);
        chk("lh_mis_rdata", r_rd, 32'h0);
        step();
        req(1, 0, 2'd0, 0, 2'd0, 11'd5, 1, 32'h0);
        wait_resp(lat, r_rd, r_ec, r_we, r_wd);
        chk("lw_inv_exc", {30'b0, r_ec}, 32'h1);
        step();
        req(1, 0, 2'd3, 0, 2'd0, 11'd5, 0, 32'h0);
        wait_resp(lat, r_rd, r_ec, r_we, r_wd);
        chk("rsvd_exc", {30'b0, r_ec}, 32'h3);
        step();
        chk("err_ram5_kept", ram[5], 32'h8899_CCBB);

        // reqValid with no operation: ignored
        reqValid = 1'b1; memRead = 1'b0; memWrite = 1'b0;
        repeat (4) step();
        chk("noop_reqReady", {31'b0, reqReady}, 32'h1);
        reqValid = 1'b0;
        step();

        // back-to-back sw then lw to the same word, reqValid held
        reqValid = 1'b1; memRead = 1'b0; memWrite = 1'b1; memSize = 2'd0; addrLow = 2'd0;
        physicalAddr = 11'd9; invAddr = 1'b0; wdata = 32'hCAFE_F00D;
        lat = 0;
        while (reqReady !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        step();
        memRead = 1'b1; memWrite = 1'b0; bitXtend = 1'b0;
        @(negedge clk);
        chk("b2b_sw_resp", {31'b0, respValid}, 32'h1);
        @(negedge clk);
        chk("b2b_ready", {31'b0, reqReady}, 32'h1);
        step();
        reqValid = 1'b0;
        @(negedge clk);
        chk("b2b_lw_busy", {31'b0, respValid}, 32'h0);
        @(negedge clk);
        chk("b2b_lw_resp", {31'b0, respValid}, 32'h1);
        chk("b2b_lw_rdata", rdata, 32'hCAFE_F00D);
        step();

        // reset while an sh is in its read phase
        req(0, 1, 2'd1, 0, 2'd2, 11'd7, 0, 32'h0000_5555);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ramWe", {31'b0, ramWe}, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_reqReady", {31'b0, reqReady}, 32'h1);
        chk("rstmid_respValid", {31'b0, respValid}, 32'h0);
        repeat (3) step();
        chk("rstmid_ram7", ram[7], 32'h0BAD_BEEF);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic        rd, wr, xt, inv;
            logic [1:0]  sz, al;
            logic [10:0] pa;
            int          r;
            repeat ($urandom_range(0, 2)) step();
            r = $urandom_range(0, 7);
            rd = (r == 1) || (r >= 2 && r <= 4);
            wr = (r == 1) || (r >= 5);
            r = $urandom_range(0, 9);
            sz = (r <= 2) ? 2'd0 : (r <= 5) ? 2'd1 : (r <= 8) ? 2'd2 : 2'd3;
            al  = 2'($urandom_range(0, 3));
            xt  = 1'($urandom_range(0, 1));
            inv = ($urandom_range(0, 15) == 0);
            pa  = 11'($urandom_range(0, 15));
            req(rd, wr, sz, xt, al, pa, inv, $urandom);
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
        end
        repeat (6) step();

        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 2048; i++) begin
                if (ram[i] !== ref_mem[i]) begin
                    if (bad < 4) $display("FAIL ram_image[%0d]: got %h expected %h", i, ram[i], ref_mem[i]);
                    bad++;
                end
            end
            checks++;
            if (bad != 0) errors++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
